// File: rtl/iic_cfg_seq.sv
// Power-up register configuration sequencer: walks a NUM_REGS-entry table and
// hands one write per entry to an I2C byte driver, with retries and timeouts.
module iic_cfg_seq #(
    parameter int unsigned NUM_REGS  = 16,
    parameter logic [7:0]  DEV_ADDR  = 8'h78,
    parameter int unsigned PWR_DLY   = 1024,
    parameter int unsigned GAP_DLY   = 8,
    parameter int unsigned RETRY_MAX = 3,
    parameter int unsigned BUSY_TMO  = 16
) (
    input  logic        clk_i,
    input  logic        rst,
    input  logic        start_cfg,
    output logic [7:0]  cfg_index,
    input  logic [23:0] cfg_data,
    output logic        start_en,
    output logic        wr_rd_flag,
    output logic [7:0]  i2c_device_addr,
    output logic [15:0] register,
    output logic [7:0]  data_byte,
    input  logic        busy,
    input  logic        err,
    output logic        cfg_done,
    output logic        cfg_fail,
    output logic [7:0]  fail_index,
    output logic [1:0]  retry_cnt
);

    typedef enum logic [2:0] {
        PWR_WAIT,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        CHECK,
        GAP,
        DONE,
        FAIL
    } state_t;

    localparam logic [8:0]  LAST_CNT  = 9'(NUM_REGS);
    localparam logic [1:0]  RETRY_LIM = 2'(RETRY_MAX);
    localparam logic [31:0] PWR_LAST  = (PWR_DLY  == 0) ? 32'd0 : 32'(PWR_DLY - 1);
    localparam logic [31:0] GAP_LAST  = (GAP_DLY  == 0) ? 32'd0 : 32'(GAP_DLY - 1);
    localparam logic [31:0] TMO_LAST  = (BUSY_TMO == 0) ? 32'd0 : 32'(BUSY_TMO - 1);

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  cfg_index_q, cfg_index_d;
    logic [1:0]  retry_cnt_q, retry_cnt_d;
    logic        att_fail_q, att_fail_d;
    logic        start_en_q, start_en_d;
    logic [15:0] register_q, register_d;
    logic [7:0]  data_byte_q, data_byte_d;
    logic        cfg_done_q, cfg_done_d;
    logic        cfg_fail_q, cfg_fail_d;
    logic [7:0]  fail_index_q, fail_index_d;
    logic [8:0]  idx_inc;

    assign idx_inc = {1'b0, cfg_index_q} + 9'd1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cfg_index_d  = cfg_index_q;
        retry_cnt_d  = retry_cnt_q;
        att_fail_d   = att_fail_q;
        start_en_d   = 1'b0;
        register_d   = register_q;
        data_byte_d  = data_byte_q;
        cfg_done_d   = cfg_done_q;
        cfg_fail_d   = cfg_fail_q;
        fail_index_d = fail_index_q;

        case (state_q)
            PWR_WAIT: begin
                if (cnt_q == PWR_LAST) begin
                    cnt_d   = '0;
                    state_d = ISSUE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ISSUE: begin
                // Holding here while busy keeps a request off a still-busy driver.
                if (!busy) begin
                    register_d  = cfg_data[23:8];
                    data_byte_d = cfg_data[7:0];
                    start_en_d  = 1'b1;
                    att_fail_d  = 1'b0;
                    cnt_d       = '0;
                    state_d     = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (busy) begin
                    state_d = WAIT_LO;
                end else if (cnt_q == TMO_LAST) begin
                    att_fail_d = 1'b1;
                    state_d    = CHECK;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            WAIT_LO: begin
                if (!busy) begin
                    att_fail_d = err;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                cnt_d = '0;
                if (!att_fail_q) begin
                    retry_cnt_d = '0;
                    // Completion wraps the index to 0 for every table size, so
                    // it never holds NUM_REGS (and 256 naturally wraps).
                    if (idx_inc == LAST_CNT) begin
                        cfg_index_d = '0;
                        cfg_done_d  = 1'b1;
                        state_d     = DONE;
                    end else begin
                        cfg_index_d = idx_inc[7:0];
                        state_d     = GAP;
                    end
                end else if (retry_cnt_q < RETRY_LIM) begin
                    retry_cnt_d = retry_cnt_q + 2'd1;
                    state_d     = GAP;
                end else begin
                    fail_index_d = cfg_index_q;
                    cfg_fail_d   = 1'b1;
                    state_d      = FAIL;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ISSUE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            DONE, FAIL: begin
                if (start_cfg) begin
                    cfg_done_d  = 1'b0;
                    cfg_fail_d  = 1'b0;
                    cfg_index_d = '0;
                    retry_cnt_d = '0;
                    cnt_d       = '0;
                    state_d     = GAP;
                end
            end
            default: state_d = PWR_WAIT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q      <= PWR_WAIT;
            cnt_q        <= '0;
            cfg_index_q  <= '0;
            retry_cnt_q  <= '0;
            att_fail_q   <= 1'b0;
            start_en_q   <= 1'b0;
            register_q   <= '0;
            data_byte_q  <= '0;
            cfg_done_q   <= 1'b0;
            cfg_fail_q   <= 1'b0;
            fail_index_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cfg_index_q  <= cfg_index_d;
            retry_cnt_q  <= retry_cnt_d;
            att_fail_q   <= att_fail_d;
            start_en_q   <= start_en_d;
            register_q   <= register_d;
            data_byte_q  <= data_byte_d;
            cfg_done_q   <= cfg_done_d;
            cfg_fail_q   <= cfg_fail_d;
            fail_index_q <= fail_index_d;
        end
    end

    assign cfg_index       = cfg_index_q;
    assign start_en        = start_en_q;
    assign wr_rd_flag      = 1'b0;
    assign i2c_device_addr = DEV_ADDR;
    assign register        = register_q;
    assign data_byte       = data_byte_q;
    assign cfg_done        = cfg_done_q;
    assign cfg_fail        = cfg_fail_q;
    assign fail_index      = fail_index_q;
    assign retry_cnt       = retry_cnt_q;

endmodule

// File: tb/tb_iic_cfg_seq.sv
// Directed bench for iic_cfg_seq: 3-entry table, behavioural I2C driver with
// programmable NACKs and a "never busy" mode.
module tb_iic_cfg_seq;

    localparam int NR = 3;
    localparam int PD = 20;
    localparam int GD = 4;
    localparam int RM = 3;
    localparam int BT = 6;

    logic        clk_i = 1'b0;
    logic        rst = 1'b1;
    logic        start_cfg = 1'b0;
    logic [7:0]  cfg_index;
    logic [23:0] cfg_data;
    logic        start_en;
    logic        wr_rd_flag;
    logic [7:0]  i2c_device_addr;
    logic [15:0] register;
    logic [7:0]  data_byte;
    logic        busy = 1'b0;
    logic        err = 1'b0;
    logic        cfg_done;
    logic        cfg_fail;
    logic [7:0]  fail_index;
    logic [1:0]  retry_cnt;

    int checks = 0;
    int errors = 0;

    iic_cfg_seq #(
        .NUM_REGS (NR),
        .DEV_ADDR (8'h78),
        .PWR_DLY  (PD),
        .GAP_DLY  (GD),
        .RETRY_MAX(RM),
        .BUSY_TMO (BT)
    ) dut (
        .clk_i          (clk_i),
        .rst            (rst),
        .start_cfg      (start_cfg),
        .cfg_index      (cfg_index),
        .cfg_data       (cfg_data),
        .start_en       (start_en),
        .wr_rd_flag     (wr_rd_flag),
        .i2c_device_addr(i2c_device_addr),
        .register       (register),
        .data_byte      (data_byte),
        .busy           (busy),
        .err            (err),
        .cfg_done       (cfg_done),
        .cfg_fail       (cfg_fail),
        .fail_index     (fail_index),
        .retry_cnt      (retry_cnt)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        case (cfg_index)
            8'd0:    cfg_data = 24'h123456;
            8'd1:    cfg_data = 24'h200001;
            8'd2:    cfg_data = 24'h3FFFA5;
            default: cfg_data = 24'h000000;
        endcase
    end

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Driver model: busy high for 4 negedges starting one cycle after start_en.
    int          phase = 0;
    int          nack_entry = -1;
    int          nack_left = 0;
    logic        no_busy = 1'b0;
    int          cur_idx = 0;
    logic [23:0] cur_word = '0;
    int          last_fall_cyc = 0;
    int          busy_viol = 0;
    int          reg_viol = 0;
    int          st_idx[$];
    int          st_retry[$];
    int          st_cyc[$];
    logic [23:0] st_word[$];

    always @(negedge clk_i) begin
        if (rst) begin
            busy  = 1'b0;
            err   = 1'b0;
            phase = 0;
        end else if (start_en) begin
            if (busy) busy_viol++;
            st_idx.push_back(int'(cfg_index));
            st_retry.push_back(int'(retry_cnt));
            st_cyc.push_back(cyc);
            st_word.push_back({register, data_byte});
            cur_idx  = int'(cfg_index);
            cur_word = {register, data_byte};
            phase    = no_busy ? 0 : 1;
        end else if (phase == 1) begin
            busy  = 1'b1;
            phase = 2;
        end else if (phase == 2 || phase == 3) begin
            phase++;
        end else if (phase == 4) begin
            busy  = 1'b0;
            phase = 0;
            last_fall_cyc = cyc;
            if (cur_idx == nack_entry && nack_left > 0) begin
                err = 1'b1;
                nack_left--;
            end else begin
                err = 1'b0;
            end
            if ({register, data_byte} !== cur_word) reg_viol++;
        end
    end

    task automatic clear_log();
        st_idx.delete();
        st_retry.delete();
        st_cyc.delete();
        st_word.delete();
        busy_viol = 0;
        reg_viol  = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst = 1'b1;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic wait_end(input int budget, output int end_cyc);
        bit seen = 0;
        end_cyc = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk_i);
            if (cfg_done || cfg_fail) begin
                seen = 1;
                end_cyc = cyc;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_end: no done/fail within %0d cycles (got 0 required 1)", budget);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({start_en, cfg_done, cfg_fail, retry_cnt, cfg_index, fail_index, register, data_byte} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got idx=%0d reg=%h data=%h se=%b done=%b fail=%b required all zero",
                     cfg_index, register, data_byte, start_en, cfg_done, cfg_fail);
        end
        checks++;
        if (wr_rd_flag !== 1'b0 || i2c_device_addr !== 8'h78) begin
            errors++;
            $display("FAIL const_outputs: got wr=%b addr=%h required wr=0 addr=78", wr_rd_flag, i2c_device_addr);
        end
    endtask

    task automatic test_all_ack();
        int rel;
        int endc;
        logic [23:0] exp_w[3] = '{24'h123456, 24'h200001, 24'h3FFFA5};
        clear_log();
        nack_entry = -1;
        no_busy = 1'b0;
        do_reset();
        rst = 1'b0;
        rel = cyc;
        wait_end(400, endc);
        checks++;
        if (st_idx.size() != 3) begin
            errors++;
            $display("FAIL ack_starts: got %0d required 3", st_idx.size());
        end
        checks++;
        if (st_cyc.size() < 1 || st_cyc[0] - rel != PD + 1) begin
            errors++;
            $display("FAIL ack_pwr_latency: got %0d required %0d", st_cyc.size() ? st_cyc[0] - rel : -1, PD + 1);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= st_word.size() || st_word[i] !== exp_w[i] || st_idx[i] != i) begin
                errors++;
                $display("FAIL ack_entry%0d: got %h required %h", i, (i < st_word.size()) ? st_word[i] : 24'hx, exp_w[i]);
            end
        end
        checks++;
        if (st_cyc.size() < 2 || st_cyc[1] - st_cyc[0] != GD + 7) begin
            errors++;
            $display("FAIL ack_spacing: got %0d required %0d", (st_cyc.size() > 1) ? st_cyc[1] - st_cyc[0] : -1, GD + 7);
        end
        checks++;
        if (endc - last_fall_cyc != 2) begin
            errors++;
            $display("FAIL ack_done_latency: got %0d required 2", endc - last_fall_cyc);
        end
        checks++;
        if (cfg_done !== 1'b1 || cfg_fail !== 1'b0 || cfg_index !== 8'd0) begin
            errors++;
            $display("FAIL ack_final: got done=%b fail=%b idx=%0d required 1 0 0", cfg_done, cfg_fail, cfg_index);
        end
        checks++;
        if (busy_viol != 0 || reg_viol != 0) begin
            errors++;
            $display("FAIL ack_protocol: got busy_viol=%0d reg_viol=%0d required 0 0", busy_viol, reg_viol);
        end
    endtask

    task automatic test_nack_once();
        int endc;
        int exp_idx[4] = '{0, 1, 1, 2};
        int exp_rty[4] = '{0, 0, 1, 0};
        clear_log();
        nack_entry = 1;
        nack_left = 1;
        do_reset();
        rst = 1'b0;
        wait_end(400, endc);
        checks++;
        if (st_idx.size() != 4) begin
            errors++;
            $display("FAIL nack1_starts: got %0d required 4", st_idx.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= st_idx.size() || st_idx[i] != exp_idx[i] || st_retry[i] != exp_rty[i]) begin
                errors++;
                $display("FAIL nack1_attempt%0d: got idx=%0d retry=%0d required idx=%0d retry=%0d", i,
                         (i < st_idx.size()) ? st_idx[i] : -1, (i < st_retry.size()) ? st_retry[i] : -1,
                         exp_idx[i], exp_rty[i]);
            end
        end
        checks++;
        if (st_word.size() < 3 || st_word[2] !== 24'h200001) begin
            errors++;
            $display("FAIL nack1_reissue_word: got %h required 200001", (st_word.size() > 2) ? st_word[2] : 24'hx);
        end
        checks++;
        if (cfg_done !== 1'b1 || cfg_fail !== 1'b0 || retry_cnt !== 2'd0) begin
            errors++;
            $display("FAIL nack1_final: got done=%b fail=%b retry=%0d required 1 0 0", cfg_done, cfg_fail, retry_cnt);
        end
    endtask

    task automatic test_nack_always();
        int endc;
        int exp_idx[6] = '{0, 1, 2, 2, 2, 2};
        int exp_rty[6] = '{0, 0, 0, 1, 2, 3};
        clear_log();
        nack_entry = 2;
        nack_left = 1000;
        do_reset();
        rst = 1'b0;
        wait_end(500, endc);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= st_idx.size() || st_idx[i] != exp_idx[i] || st_retry[i] != exp_rty[i]) begin
                errors++;
                $display("FAIL nackall_attempt%0d: got idx=%0d retry=%0d required idx=%0d retry=%0d", i,
                         (i < st_idx.size()) ? st_idx[i] : -1, (i < st_retry.size()) ? st_retry[i] : -1,
                         exp_idx[i], exp_rty[i]);
            end
        end
        checks++;
        if (cfg_fail !== 1'b1 || cfg_done !== 1'b0 || fail_index !== 8'd2) begin
            errors++;
            $display("FAIL nackall_final: got fail=%b done=%b fidx=%0d required 1 0 2", cfg_fail, cfg_done, fail_index);
        end
        repeat (60) @(negedge clk_i);
        checks++;
        if (st_idx.size() != 6 || cfg_fail !== 1'b1) begin
            errors++;
            $display("FAIL nackall_quiet: got starts=%0d fail=%b required 6 1", st_idx.size(), cfg_fail);
        end
        nack_entry = -1;
        nack_left = 0;
    endtask

    task automatic test_busy_timeout();
        int endc;
        clear_log();
        no_busy = 1'b1;
        do_reset();
        rst = 1'b0;
        wait_end(500, endc);
        checks++;
        if (st_idx.size() != 4 || st_idx.sum() != 0) begin
            errors++;
            $display("FAIL tmo_starts: got %0d starts required 4 on entry 0", st_idx.size());
        end
        checks++;
        if (st_cyc.size() < 2 || st_cyc[1] - st_cyc[0] != BT + GD + 2) begin
            errors++;
            $display("FAIL tmo_spacing: got %0d required %0d", (st_cyc.size() > 1) ? st_cyc[1] - st_cyc[0] : -1, BT + GD + 2);
        end
        checks++;
        if (cfg_fail !== 1'b1 || fail_index !== 8'd0 || cfg_done !== 1'b0) begin
            errors++;
            $display("FAIL tmo_final: got fail=%b fidx=%0d done=%b required 1 0 0", cfg_fail, fail_index, cfg_done);
        end
        no_busy = 1'b0;
    endtask

    task automatic test_start_cfg();
        int endc;
        int p;
        bit seen = 0;
        clear_log();
        do_reset();
        rst = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_i);
            seen = busy;
        end
        @(negedge clk_i);
        start_cfg = 1'b1;
        @(negedge clk_i);
        start_cfg = 1'b0;
        wait_end(400, endc);
        checks++;
        if (st_idx.size() != 3 || st_idx[0] != 0 || cfg_done !== 1'b1) begin
            errors++;
            $display("FAIL startcfg_ignored: got starts=%0d done=%b required 3 1", st_idx.size(), cfg_done);
        end
        clear_log();
        p = cyc;
        start_cfg = 1'b1;
        @(negedge clk_i);
        start_cfg = 1'b0;
        checks++;
        if (cfg_done !== 1'b0 || cfg_index !== 8'd0) begin
            errors++;
            $display("FAIL startcfg_clear: got done=%b idx=%0d required 0 0", cfg_done, cfg_index);
        end
        wait_end(400, endc);
        checks++;
        if (st_cyc.size() < 1 || st_cyc[0] - p != GD + 2 || st_idx[0] != 0) begin
            errors++;
            $display("FAIL startcfg_rerun_latency: got %0d required %0d", st_cyc.size() ? st_cyc[0] - p : -1, GD + 2);
        end
        checks++;
        if (st_idx.size() != 3 || cfg_done !== 1'b1) begin
            errors++;
            $display("FAIL startcfg_rerun: got starts=%0d done=%b required 3 1", st_idx.size(), cfg_done);
        end
    endtask

    task automatic test_rst_mid();
        int rel;
        bit seen = 0;
        clear_log();
        do_reset();
        rst = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk_i);
            seen = busy && (cfg_index == 8'd1);
        end
        @(negedge clk_i);
        rst = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({start_en, cfg_done, cfg_fail, retry_cnt, cfg_index, fail_index, register, data_byte} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got idx=%0d reg=%h data=%h se=%b required all zero",
                     cfg_index, register, data_byte, start_en);
        end
        @(negedge clk_i);
        clear_log();
        rst = 1'b0;
        rel = cyc;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_i);
            seen = (st_idx.size() > 0);
        end
        checks++;
        if (!seen || st_cyc[0] - rel != PD + 1 || st_idx[0] != 0) begin
            errors++;
            $display("FAIL rstmid_restart: got %0d required %0d", seen ? st_cyc[0] - rel : -1, PD + 1);
        end
    endtask

    initial begin
        test_reset();
        test_all_ack();
        test_nack_once();
        test_nack_always();
        test_busy_timeout();
        test_start_cfg();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iic_cfg_seq.md
IIC_CFG_SEQ -- requirements
Module: iic_cfg_seq

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16: number of table entries written per configuration run (1..256).
REQ-002 SHALL have parameter DEV_ADDR, default 8'h78: 8-bit device address; bit 0 is ignored by the downstream driver.
REQ-003 SHALL have parameter PWR_DLY, default 1024: idle cycles after reset before the first transfer.
REQ-004 SHALL have parameter GAP_DLY, default 8: idle cycles between consecutive transfers.
REQ-005 SHALL have parameter RETRY_MAX, default 3: retries per entry after the first attempt fails.
REQ-006 SHALL have parameter BUSY_TMO, default 16: cycles allowed for busy to rise after start_en.
REQ-007 SHALL use one clock and a synchronous, active-high reset, with ports clk_i (input, 1, I2C bit-rate clock, same clock as the I2C driver) and rst (input, 1, synchronous active-high reset).
REQ-008 SHALL have port start_cfg: input, 1, pulse that requests a full rerun from entry 0; honoured only in DONE or FAIL.
REQ-009 SHALL have port cfg_index: output, 8, table address of the current entry.
REQ-010 SHALL have port cfg_data: input, 24, {reg[15:0], data[7:0]} returned combinationally for cfg_index.
REQ-011 SHALL have port start_en: output, 1, one-cycle transfer request to the driver.
REQ-012 SHALL have port wr_rd_flag: output, 1, driven constant 0 (write).
REQ-013 SHALL have port i2c_device_addr: output, 8, equal to DEV_ADDR.
REQ-014 SHALL have port register: output, 16, register address.
REQ-015 SHALL have port data_byte: output, 8, register data.
REQ-016 SHALL have port busy: input, 1, driver busy; it rises at least one cycle after start_en.
REQ-017 SHALL have port err: input, 1, driver NACK flag, valid when busy falls.
REQ-018 SHALL have port cfg_done: output, 1, level; all entries written.
REQ-019 SHALL have port cfg_fail: output, 1, level; an entry exhausted its retries.
REQ-020 SHALL have port fail_index: output, 8, index of the failing entry.
REQ-021 SHALL have port retry_cnt: output, 2, retries used on the current entry.

Function
REQ-022 SHALL implement the FSM states PWR_WAIT, ISSUE, WAIT_HI, WAIT_LO, CHECK, GAP, DONE, FAIL.
REQ-023 PWR_WAIT SHALL count PWR_DLY cycles and then go to ISSUE; busy is ignored while in this state.
REQ-024 In ISSUE, the block SHALL latch cfg_data into register/data_byte, assert start_en for exactly one cycle, then go to WAIT_HI.
REQ-025 register and data_byte SHALL remain stable from the start_en cycle until the exit from WAIT_LO.
REQ-026 WAIT_HI SHALL go to WAIT_LO when busy=1; if busy stays 0 for BUSY_TMO cycles, it SHALL go to CHECK with the attempt marked failed.
REQ-027 WAIT_LO SHALL go to CHECK on the first cycle busy=0 and sample err in that same cycle; there is no timeout in WAIT_LO.
REQ-028 In CHECK, a successful attempt SHALL clear retry_cnt, increment cfg_index, and go to DONE if the incremented value equals NUM_REGS, otherwise to GAP.
REQ-029 In CHECK, a failed attempt SHALL go to GAP and then reissue the same entry if retry_cnt<RETRY_MAX, incrementing retry_cnt.
REQ-030 In CHECK, a failed attempt with retry_cnt==RETRY_MAX SHALL set fail_index=cfg_index and go to FAIL.
REQ-031 GAP SHALL count GAP_DLY cycles and then go to ISSUE.
REQ-032 In DONE, cfg_done SHALL be 1 and cfg_fail 0; in FAIL, cfg_fail SHALL be 1 and cfg_done 0; both flags SHALL hold until start_cfg or rst.
REQ-033 start_cfg in DONE/FAIL SHALL clear cfg_done, cfg_fail, cfg_index and retry_cnt, then go to GAP (no power-up delay); start_cfg in any other state SHALL be ignored.
REQ-034 cfg_index SHALL never reach or wrap past NUM_REGS; when NUM_REGS=256, the 8-bit index wraps to 0 and that wrap SHALL be treated as DONE.
REQ-035 A start_en pulse SHALL never be issued while busy=1.
REQ-036 All outputs SHALL be registered; start_en latency SHALL be exactly 1 cycle after ISSUE is entered.

Reset
REQ-037 rst=1 SHALL force PWR_WAIT with cfg_index=0, retry_cnt=0, start_en=0, cfg_done=0, cfg_fail=0, fail_index=0, register=16'h0000, data_byte=8'h00 on the next clk_i edge.
REQ-038 rst mid-transfer SHALL abandon the transfer and restart from PWR_WAIT; the driver's own reset handles its bus state.

Verification
REQ-039 Test: NUM_REGS=3, table {1234_56, 2000_01, 3FFF_A5}, driver model ACKs all -> three start_en pulses, register/data match the table, cfg_done=1 after the third busy fall.
REQ-040 Test: entry 1 NACKs once then ACKs -> entry 1 is issued twice, retry_cnt shows 1 then 0, cfg_done=1.
REQ-041 Test: entry 2 NACKs always, RETRY_MAX=3 -> four attempts on entry 2, cfg_fail=1, fail_index=2, and no further start_en.
REQ-042 Test: busy never rises -> BUSY_TMO timeouts count as failures, resulting in cfg_fail=1 and fail_index=0.
REQ-043 Test: start_cfg pulse while in WAIT_LO -> ignored; start_cfg pulse in DONE -> rerun from entry 0 after GAP_DLY, with no PWR_DLY.
REQ-044 Test: rst asserted during WAIT_LO -> all outputs at reset values, and the first start_en comes PWR_DLY+1 cycles after rst is released.
